// File: rtl/vram_scanout.sv
// vram_scanout: 640x480@60 timing plus 320x200x4bpp VRAM scan-out; optional vblank IRQ via VRAM_SCANOUT_VBLANK_IRQ_EN
module vram_scanout #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          V_BORDER = 40,
    parameter logic [14:0] FB_BASE  = 15'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [14:0] addr_b,
    input  logic [7:0]  dout_b,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [3:0]  pixel,
    output logic        frame_start
`ifdef VRAM_SCANOUT_VBLANK_IRQ_EN
    ,
    input  logic        irq_ack,
    output logic        vblank_irq
`endif
);

    localparam logic [9:0]  H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  HA     = 10'(H_ACTIVE);
    localparam logic [9:0]  VA     = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  WIN_LO = 10'(V_BORDER);
    localparam logic [9:0]  WIN_HI = 10'(V_ACTIVE - V_BORDER);
    localparam logic [14:0] BPL    = 15'(H_ACTIVE / 4);

    typedef struct packed {
        logic       win;
        logic       vis;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [1:0] sub;
    } stage_t;

    localparam stage_t IDLE = '{win: 1'b0, vis: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, sub: 2'd0};

    logic [9:0]  h_q, h_d, v_q, v_d, vrel;
    logic [14:0] addr_q, addr_d, src;
    logic [7:0]  byte_q, byte_d;
    logic [3:0]  pixel_q, pixel_d;
    logic        hsync_q, vsync_q, de_q, fs_q;
    logic        fetch;
    stage_t      s1_q, s1_d, s2_q;

    // Counters, fetch address and the stage-0 descriptor of the current pixel
    always_comb begin
        h_d    = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
        v_d    = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        vrel   = v_q - WIN_LO;
        src    = 15'(vrel >> 1);
        s1_d.vis = (h_q < HA) && (v_q < VA);
        s1_d.win = s1_d.vis && (v_q >= WIN_LO) && (v_q < WIN_HI);
        s1_d.hs  = !((h_q >= HS_BEG) && (h_q < HS_END));
        s1_d.vs  = !((v_q >= VS_BEG) && (v_q < VS_END));
        s1_d.fs  = (h_q == 10'd0) && (v_q == 10'd0);
        s1_d.sub = h_q[1:0];
        fetch  = s1_d.win && (h_q[1:0] == 2'd0);
        addr_d = fetch ? FB_BASE + src * BPL + {7'd0, h_q[9:2]} : addr_q;
    end

    // Byte capture and nibble select: the first pixel of a byte bypasses straight from the RAM
    always_comb begin
        byte_d  = (s2_q.win && s2_q.sub == 2'd0) ? dout_b : byte_q;
        pixel_d = !s2_q.win ? 4'd0 :
                  (s2_q.sub == 2'd0) ? dout_b[7:4] :
                  (s2_q.sub == 2'd1) ? byte_q[7:4] : byte_q[3:0];
    end

    // Counter, address and three-stage output pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            addr_q  <= FB_BASE;
            s1_q    <= IDLE;
            s2_q    <= IDLE;
            byte_q  <= 8'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            pixel_q <= 4'd0;
            fs_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            addr_q  <= addr_d;
            s1_q    <= s1_d;
            s2_q    <= s1_q;
            byte_q  <= byte_d;
            hsync_q <= s2_q.hs;
            vsync_q <= s2_q.vs;
            de_q    <= s2_q.vis;
            pixel_q <= pixel_d;
            fs_q    <= s2_q.fs;
        end
    end

    assign addr_b      = addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign pixel       = pixel_q;
    assign frame_start = fs_q;

`ifdef VRAM_SCANOUT_VBLANK_IRQ_EN
    logic [1:0] irq_pipe_q, irq_pipe_d;
    logic       irq_q, irq_d;

    // Line-480 start travels the same depth as the video outputs; a set beats a same-clock ack
    always_comb begin
        irq_pipe_d = {irq_pipe_q[0], (h_q == 10'd0) && (v_q == VA)};
        irq_d      = irq_pipe_q[1] | (irq_q & ~irq_ack);
    end

    // Interrupt flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_pipe_q <= 2'd0;
            irq_q      <= 1'b0;
        end else begin
            irq_pipe_q <= irq_pipe_d;
            irq_q      <= irq_d;
        end
    end

    assign vblank_irq = irq_q;
`endif

endmodule
